// File: rtl/out_capture.sv
// Passive observer of the processor out bus: change-detected samples of proc_out
// are queued in a small FIFO that a consumer drains with a valid/ready handshake.
module out_capture #(
  parameter int BIT_WIDTH = 4,
  parameter int DEPTH     = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en,
  input  logic [BIT_WIDTH-1:0]       proc_out,
  output logic [BIT_WIDTH-1:0]       rd_data,
  output logic                       rd_valid,
  input  logic                       rd_ready,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       overflow,
  output logic [7:0]                 drops,
  input  logic                       clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [BIT_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [BIT_WIDTH-1:0] prev;
  logic                 have_prev;

  logic capture;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Handshake: rd_valid means rd_data holds the FIFO head; the head is consumed
  // at the rising edge where rd_valid and rd_ready are both high. rd_valid never
  // depends combinationally on rd_ready.
  always_comb begin
    capture  = en && (!have_prev || (proc_out != prev));
    full     = (count == FULL_COUNT);
    rd_valid = (count != '0);
    pop      = rd_valid && rd_ready;
    push     = capture && (!full || pop);
    drop     = capture && full && !pop;
    rd_data  = rd_valid ? mem[rd_ptr] : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      prev      <= '0;
      have_prev <= 1'b0;
    end else if (en) begin
      prev      <= proc_out;
      have_prev <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage has no reset; rd_data is masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= proc_out;
  end

  // A drop in the same cycle as clr_ovf takes precedence over the clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      overflow <= 1'b0;
      drops    <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (clr_ovf)            drops <= 8'd1;
      else if (drops != 8'hff) drops <= drops + 8'd1;
    end else if (clr_ovf) begin
      overflow <= 1'b0;
      drops    <= '0;
    end
  end

endmodule

// File: tb/tb_out_capture.sv
// Directed bench for out_capture: capture, drain order, overflow, full-FIFO
// push/pop, enable gating, overflow clear and asynchronous reset.
module tb_out_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] proc_out;
  logic [3:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [3:0] count;
  logic       overflow;
  logic [7:0] drops;
  logic       clr_ovf;

  int pass_cnt = 0;
  int total_cnt = 0;

  out_capture #(.BIT_WIDTH(4), .DEPTH(8)) dut (
    .clk(clk), .rst(rst), .en(en), .proc_out(proc_out),
    .rd_data(rd_data), .rd_valid(rd_valid), .rd_ready(rd_ready),
    .count(count), .overflow(overflow), .drops(drops), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; en = 1'b1; rd_ready = 1'b1; clr_ovf = 1'b0; proc_out = 4'd0;
    for (int i = 0; i < 2; i++) begin
      proc_out = 4'(i * 5 + 3);
      step();
    end
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL rst_valid got %0b expected 0", rd_valid); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL rst_count got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL rst_ovf got %0b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (drops !== 8'd0) $display("FAIL rst_drops got %0d expected 0", drops); else pass_cnt++;
    total_cnt++; if (rd_data !== 4'd0) $display("FAIL rst_data got %0d expected 0", rd_data); else pass_cnt++;
    rd_ready = 1'b0;
    rst = 1'b1;
  endtask

  task automatic test_capture();
    logic [3:0] vals [8];
    logic [3:0] cnts [8];
    logic [3:0] outs [5];
    vals = '{4'd0, 4'd0, 4'd0, 4'd1, 4'd1, 4'd2, 4'd3, 4'd5};
    cnts = '{4'd1, 4'd1, 4'd1, 4'd2, 4'd2, 4'd3, 4'd4, 4'd5};
    outs = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5};
    en = 1'b1; rd_ready = 1'b0;
    for (int i = 0; i < 8; i++) begin
      proc_out = vals[i];
      step();
      total_cnt++;
      if (count !== cnts[i]) $display("FAIL cap_count[%0d] got %0d expected %0d", i, count, cnts[i]); else pass_cnt++;
    end
    total_cnt++; if (rd_valid !== 1'b1) $display("FAIL cap_valid got %0b expected 1", rd_valid); else pass_cnt++;
    rd_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      total_cnt++;
      if (rd_data !== outs[i]) $display("FAIL cap_data[%0d] got %0d expected %0d", i, rd_data, outs[i]); else pass_cnt++;
      step();
    end
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL cap_empty got %0b expected 0", rd_valid); else pass_cnt++;
    total_cnt++; if (rd_data !== 4'd0) $display("FAIL cap_empty_data got %0d expected 0", rd_data); else pass_cnt++;
    rd_ready = 1'b0;
  endtask

  task automatic test_overflow();
    rd_ready = 1'b0;
    for (int v = 1; v <= 10; v++) begin
      proc_out = 4'(v);
      step();
    end
    total_cnt++; if (count !== 4'd8) $display("FAIL ovf_count got %0d expected 8", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b expected 1", overflow); else pass_cnt++;
    total_cnt++; if (drops !== 8'd2) $display("FAIL ovf_drops got %0d expected 2", drops); else pass_cnt++;
    rd_ready = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      total_cnt++;
      if (rd_data !== 4'(v)) $display("FAIL ovf_data got %0d expected %0d", rd_data, v); else pass_cnt++;
      step();
    end
    total_cnt++; if (count !== 4'd0) $display("FAIL ovf_drained got %0d expected 0", count); else pass_cnt++;
    rd_ready = 1'b0;
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    total_cnt++; if (drops !== 8'd0) $display("FAIL ovf_clr_drops got %0d expected 0", drops); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    logic [3:0] exp_stream [8];
    exp_stream = '{4'd5, 4'd6, 4'd7, 4'd8, 4'd11, 4'd12, 4'd13, 4'd14};
    rd_ready = 1'b0;
    for (int v = 1; v <= 8; v++) begin
      proc_out = 4'(v);
      step();
    end
    total_cnt++; if (count !== 4'd8) $display("FAIL b2b_fill got %0d expected 8", count); else pass_cnt++;
    rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      proc_out = 4'(11 + i);
      total_cnt++;
      if (rd_data !== 4'(1 + i)) $display("FAIL b2b_head[%0d] got %0d expected %0d", i, rd_data, 1 + i); else pass_cnt++;
      step();
      total_cnt++;
      if (count !== 4'd8) $display("FAIL b2b_count[%0d] got %0d expected 8", i, count); else pass_cnt++;
    end
    total_cnt++; if (drops !== 8'd0) $display("FAIL b2b_drops got %0d expected 0", drops); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL b2b_ovf got %0b expected 0", overflow); else pass_cnt++;
    for (int i = 0; i < 8; i++) begin
      total_cnt++;
      if (rd_data !== exp_stream[i]) $display("FAIL b2b_stream[%0d] got %0d expected %0d", i, rd_data, exp_stream[i]); else pass_cnt++;
      step();
    end
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL b2b_empty got %0b expected 0", rd_valid); else pass_cnt++;
    rd_ready = 1'b0;
  endtask

  task automatic test_enable();
    rd_ready = 1'b0; en = 1'b1;
    proc_out = 4'd3;
    step();
    en = 1'b0;
    proc_out = 4'd7; step();
    proc_out = 4'd9; step();
    total_cnt++; if (count !== 4'd1) $display("FAIL en_gated got %0d expected 1", count); else pass_cnt++;
    en = 1'b1;
    step();
    total_cnt++; if (count !== 4'd2) $display("FAIL en_reenable got %0d expected 2", count); else pass_cnt++;
    step();
    total_cnt++; if (count !== 4'd2) $display("FAIL en_repeat got %0d expected 2", count); else pass_cnt++;
    rd_ready = 1'b1;
    total_cnt++; if (rd_data !== 4'd3) $display("FAIL en_data0 got %0d expected 3", rd_data); else pass_cnt++;
    step();
    total_cnt++; if (rd_data !== 4'd9) $display("FAIL en_data1 got %0d expected 9", rd_data); else pass_cnt++;
    step();
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL en_empty got %0b expected 0", rd_valid); else pass_cnt++;
    rd_ready = 1'b0;
  endtask

  task automatic test_clr_ovf();
    rd_ready = 1'b0; en = 1'b1;
    for (int v = 1; v <= 8; v++) begin
      proc_out = 4'(v);
      step();
    end
    proc_out = 4'd15; clr_ovf = 1'b1;
    step();
    total_cnt++; if (overflow !== 1'b1) $display("FAIL clr_race_ovf got %0b expected 1", overflow); else pass_cnt++;
    total_cnt++; if (drops !== 8'd1) $display("FAIL clr_race_drops got %0d expected 1", drops); else pass_cnt++;
    step();
    clr_ovf = 1'b0;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL clr_ovf got %0b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (drops !== 8'd0) $display("FAIL clr_drops got %0d expected 0", drops); else pass_cnt++;
    proc_out = 4'd14; step();
    proc_out = 4'd13; step();
    total_cnt++; if (drops !== 8'd2) $display("FAIL clr_recount got %0d expected 2", drops); else pass_cnt++;
    total_cnt++; if (rd_data !== 4'd1) $display("FAIL clr_oldest got %0d expected 1", rd_data); else pass_cnt++;
    rd_ready = 1'b1;
    step();
    total_cnt++; if (rd_data !== 4'd2) $display("FAIL clr_drain got %0d expected 2", rd_data); else pass_cnt++;
    rd_ready = 1'b0;
    rst = 1'b0;
    #1;
    total_cnt++; if (rd_valid !== 1'b0) $display("FAIL mid_rst_valid got %0b expected 0", rd_valid); else pass_cnt++;
    total_cnt++; if (count !== 4'd0) $display("FAIL mid_rst_count got %0d expected 0", count); else pass_cnt++;
    total_cnt++; if (overflow !== 1'b0) $display("FAIL mid_rst_ovf got %0b expected 0", overflow); else pass_cnt++;
    total_cnt++; if (drops !== 8'd0) $display("FAIL mid_rst_drops got %0d expected 0", drops); else pass_cnt++;
    total_cnt++; if (rd_data !== 4'd0) $display("FAIL mid_rst_data got %0d expected 0", rd_data); else pass_cnt++;
    step();
    rst = 1'b1;
    step();
    total_cnt++; if (count !== 4'd1) $display("FAIL first_after_rst got %0d expected 1", count); else pass_cnt++;
    total_cnt++; if (rd_data !== 4'd13) $display("FAIL first_data got %0d expected 13", rd_data); else pass_cnt++;
  endtask

  task automatic test_saturation();
    rd_ready = 1'b0; en = 1'b1;
    for (int v = 1; v <= 7; v++) begin
      proc_out = 4'(v);
      step();
    end
    total_cnt++; if (count !== 4'd8) $display("FAIL sat_fill got %0d expected 8", count); else pass_cnt++;
    for (int i = 0; i < 260; i++) begin
      proc_out = (i % 2 == 0) ? 4'd14 : 4'd15;
      step();
    end
    total_cnt++; if (drops !== 8'd255) $display("FAIL sat_drops got %0d expected 255", drops); else pass_cnt++;
    total_cnt++; if (rd_data !== 4'd13) $display("FAIL sat_head got %0d expected 13", rd_data); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; proc_out = 4'd0; rd_ready = 1'b0; clr_ovf = 1'b0;
    test_reset();
    test_capture();
    test_overflow();
    test_back_to_back();
    test_enable();
    test_clr_ovf();
    test_saturation();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
